// File: rtl/mem_if_pkg.sv
// Shared types for the native PicoRV32 memory port: request payload, widths, arbiter state.
// Pure declarations; no latency or flow control of its own.
package mem_if_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_STRB_W = 4;

   typedef struct packed {
      logic                  instr;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
      logic [MEM_STRB_W-1:0] wstrb;
   } mem_req_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_2to1_rr_pick2.sv
// Two-way round-robin pick: combinational, zero latency; on a tie the requester
// that did not win last time is chosen (last = 1 means requester 1 won last).
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      unique case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Round-robin 2:1 arbiter onto one PicoRV32 memory port; grant registers the payload (valid->m_mem_valid 1 cycle),
// one transaction outstanding, requesters stall on their ready; optional watchdog aborts hung transactions.
module mem_arbiter_2to1
   import mem_if_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter logic [MEM_DATA_W-1:0] ERR_RDATA = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  resetn,

   input  logic                  s0_mem_valid,
   input  logic                  s0_mem_instr,
   output logic                  s0_mem_ready,
   input  logic [MEM_ADDR_W-1:0] s0_mem_addr,
   input  logic [MEM_DATA_W-1:0] s0_mem_wdata,
   input  logic [MEM_STRB_W-1:0] s0_mem_wstrb,
   output logic [MEM_DATA_W-1:0] s0_mem_rdata,

   input  logic                  s1_mem_valid,
   input  logic                  s1_mem_instr,
   output logic                  s1_mem_ready,
   input  logic [MEM_ADDR_W-1:0] s1_mem_addr,
   input  logic [MEM_DATA_W-1:0] s1_mem_wdata,
   input  logic [MEM_STRB_W-1:0] s1_mem_wstrb,
   output logic [MEM_DATA_W-1:0] s1_mem_rdata,

   output logic                  m_mem_valid,
   output logic                  m_mem_instr,
   input  logic                  m_mem_ready,
   output logic [MEM_ADDR_W-1:0] m_mem_addr,
   output logic [MEM_DATA_W-1:0] m_mem_wdata,
   output logic [MEM_STRB_W-1:0] m_mem_wstrb,
   input  logic [MEM_DATA_W-1:0] m_mem_rdata,

   output logic [1:0]            grant,
   output logic                  timeout_err
);

   localparam int         CNT_W  = 16;
   localparam logic       WD_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t       state_q, state_d;
   mem_req_t         req_q, req_d;
   logic [1:0]       grant_q, grant_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             terr_q, terr_d;

   logic [1:0] win;
   mem_req_t   s0_req, s1_req, win_req;
   logic       wd_hit;
   logic       done;

   assign s0_req  = '{instr: s0_mem_instr, addr: s0_mem_addr, wdata: s0_mem_wdata, wstrb: s0_mem_wstrb};
   assign s1_req  = '{instr: s1_mem_instr, addr: s1_mem_addr, wdata: s1_mem_wdata, wstrb: s1_mem_wstrb};
   assign win_req = win[1] ? s1_req : s0_req;

   rr_pick2 u_pick (
      .req  ({s1_mem_valid, s0_mem_valid}),
      .last (last_q),
      .win  (win)
   );

   // A downstream ready in the watchdog cycle takes precedence over the abort.
   assign wd_hit = WD_EN && (state_q == BUSY) && (cnt_q == WD_LIM) && !m_mem_ready;
   assign done   = (state_q == BUSY) && (m_mem_ready || wd_hit);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      terr_d  = terr_q;
      unique case (state_q)
         IDLE: begin
            if (|win) begin
               req_d   = win_req;
               grant_d = win;
               last_d  = win[1];
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (done) begin
               grant_d = 2'b00;
               state_d = IDLE;
               if (wd_hit) begin
                  terr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         req_q   <= '0;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   assign m_mem_valid = (state_q == BUSY);
   assign m_mem_instr = req_q.instr;
   assign m_mem_addr  = req_q.addr;
   assign m_mem_wdata = req_q.wdata;
   assign m_mem_wstrb = req_q.wstrb;

   assign s0_mem_ready = done && grant_q[0];
   assign s1_mem_ready = done && grant_q[1];
   assign s0_mem_rdata = wd_hit ? ERR_RDATA : m_mem_rdata;
   assign s1_mem_rdata = wd_hit ? ERR_RDATA : m_mem_rdata;

   assign grant       = grant_q;
   assign timeout_err = terr_q;

endmodule

// File: doc/mem_arbiter_2to1.md
Name: mem_arbiter_2to1

Overview:
- Shares one native PicoRV32 memory port (valid/instr/ready/addr/wdata/wstrb/rdata) between two requesters.
- Typical requesters: two cores, or one core plus a DMA/debug master.
- Sits between the requesters' mem_* buses and the single downstream memory or interconnect.
- Round-robin arbitration, one outstanding transaction at a time, optional watchdog that aborts a hung downstream transaction.

Parameters:
- TIMEOUT_CYCLES, 0: cycles in BUSY before a transaction is aborted; 0 disables the watchdog. Legal range 0 or 2..65535.
- ERR_RDATA, 32'hDEADBEEF: rdata returned to the requester on a timeout abort.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- s0_mem_valid  in  1  requester 0 request
- s0_mem_instr  in  1  requester 0 instruction-fetch flag
- s0_mem_ready  out  1  requester 0 completion strobe
- s0_mem_addr  in  32  requester 0 byte address
- s0_mem_wdata  in  32  requester 0 write data
- s0_mem_wstrb  in  4  requester 0 byte enables; 0 = read
- s0_mem_rdata  out  32  requester 0 read data
- s1_mem_*  same set, requester 1
- m_mem_valid  out  1  downstream request
- m_mem_instr  out  1  downstream instruction flag
- m_mem_ready  in  1  downstream completion
- m_mem_addr  out  32  downstream address
- m_mem_wdata  out  32  downstream write data
- m_mem_wstrb  out  4  downstream byte enables
- m_mem_rdata  in  32  downstream read data
- grant  out  2  one-hot current owner; 00 when idle
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async assert, deassert sampled on clk): state IDLE; m_mem_valid/instr/addr/wdata/wstrb = 0; grant = 00; timeout_err = 0; last_grant = 1, so s0 wins the first tie; watchdog counter = 0.
- Reset mid-transaction drops m_mem_valid immediately. No ready is returned to either requester.
- States: IDLE, BUSY.
- IDLE:
  - Neither valid: stay in IDLE.
  - One valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - On a grant, at the clock edge: register the winner's instr/addr/wdata/wstrb into m_mem_*; set m_mem_valid = 1; set grant; set last_grant = winner; clear the counter; go to BUSY.
  - Latency: valid seen in cycle N gives m_mem_valid in cycle N+1.
- BUSY:
  - m_mem_* are held stable until completion.
  - The counter increments each cycle in BUSY, saturating.
  - On m_mem_ready = 1: sX_mem_ready = 1 combinationally, same cycle, for the granted requester only. Next edge: m_mem_valid = 0, grant = 00, go to IDLE.
  - Watchdog (TIMEOUT_CYCLES > 0): when counter == TIMEOUT_CYCLES and m_mem_ready = 0, assert sX_mem_ready for one cycle with rdata = ERR_RDATA. Set timeout_err = 1 (cleared only by reset), deassert m_mem_valid, go to IDLE.
  - m_mem_ready and the timeout in the same cycle: m_mem_ready wins; normal completion, no error.
- sX_mem_rdata = m_mem_rdata, except ERR_RDATA on an abort. It is only meaningful while sX_mem_ready = 1.
- Minimum turnaround: one IDLE cycle between transactions, so back-to-back throughput is one transaction per (downstream latency + 2) cycles.
- m_mem_ready while in IDLE (late response after an abort, or a protocol violation) is ignored; no ready is forwarded.
- A requester dropping valid while it is granted is a protocol violation. The downstream transaction still completes; the completion ready is still pulsed to that requester.
- A requester must hold valid and payload until its ready. Its payload is sampled only at grant.

Decomposition:
- Shared package mem_if_pkg:
  - struct mem_req_t {instr, addr, wdata, wstrb}
  - constants MEM_ADDR_W = 32, MEM_DATA_W = 32, MEM_STRB_W = 4
  - enum arb_state_t {IDLE, BUSY}
- The arbitration decision is a natural sub-module, rr_pick2: inputs req[1:0] and last; outputs one-hot win[1:0].
- The watchdog counter stays inline.

Test Plan:
- Single read: s0 valid, addr 0x100, wstrb 0; memory returns 0x12345678 after 3 cycles → m_mem_valid in cycle 1 with addr 0x100; s0_mem_ready pulses once with rdata 0x12345678; grant 01 then 00; s1_mem_ready stays 0.
- Tie after reset: s0 and s1 valid in the same cycle → s0 granted first, s1 next. With both held continuously for 6 transactions, grant alternates 01,10,01,10,01,10.
- Write passthrough: s1 writes addr 0x200, wdata 0xA5A5A5A5, wstrb 0011 → downstream sees exactly those values, stable until m_mem_ready; s1_mem_ready pulses once.
- Timeout: TIMEOUT_CYCLES = 8, memory never responds → s0_mem_ready after 8 BUSY cycles with rdata 0xDEADBEEF; timeout_err = 1 and stays 1. A late m_mem_ready in IDLE produces no ready on either requester.
- Ready/timeout collision: m_mem_ready arrives in exactly the timeout cycle → normal rdata delivered, timeout_err stays 0.
- Async reset mid-BUSY: assert resetn low between clock edges → m_mem_valid and grant go to 0 without waiting for an edge; no ready is pulsed. After release, a tie grants s0 first.
